writeback_arbiter: RTL and testbench

//   Producer side of the register-file write port. Merges results from the single-cycle

---
 rtl/writeback_arbiter_pkg.sv | 28 ++
 rtl/writeback_arbiter_if.sv | 45 ++++
 rtl/writeback_arbiter_wb_fifo.sv | 55 +++++
 rtl/writeback_arbiter.sv | 87 ++++++++
 tb/tb_writeback_arbiter.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/writeback_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package writeback_arbiter_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xword_t;
    typedef logic [NUM_REGS-1:0]   reg_mask_t;

    // One queued M-unit result.
    typedef struct packed {
        reg_addr_t rd;
        xword_t    data;
    } wb_entry_t;

    // One-hot mask for a register index; x0 never gets a bit.
    function automatic reg_mask_t reg_onehot(input reg_addr_t rd);
        reg_mask_t m;
        m = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            m[i] = (rd == REG_ADDR_W'(i));
        end
        return m;
    endfunction

endpackage

// File: rtl/writeback_arbiter_if.sv
// Writeback bus: execute path, M-unit results/issue, hazard check and RF write port.
interface writeback_arbiter_if;
    import writeback_arbiter_pkg::*;

    logic      pipe_valid;
    reg_addr_t pipe_rd;
    xword_t    pipe_data;

    logic      md_valid;
    logic      md_ready;
    reg_addr_t md_rd;
    xword_t    md_data;

    logic      issue_valid;
    reg_addr_t issue_rd;

    reg_addr_t chk_rs1;
    reg_addr_t chk_rs2;
    logic      hazard;
    reg_mask_t pending;

    logic      rf_we;
    reg_addr_t rf_rd;
    xword_t    rf_wdata;

    // Pipeline control / producers side.
    modport master (
        output pipe_valid, pipe_rd, pipe_data,
        output md_valid, md_rd, md_data,
        output issue_valid, issue_rd,
        output chk_rs1, chk_rs2,
        input  md_ready, hazard, pending,
        input  rf_we, rf_rd, rf_wdata
    );

    // The arbiter itself.
    modport slave (
        input  pipe_valid, pipe_rd, pipe_data,
        input  md_valid, md_rd, md_data,
        input  issue_valid, issue_rd,
        input  chk_rs1, chk_rs2,
        output md_ready, hazard, pending,
        output rf_we, rf_rd, rf_wdata
    );
endinterface

// File: rtl/writeback_arbiter_wb_fifo.sv
// Circular queue of M-unit results. Extra pointer MSB distinguishes full from empty.
module wb_fifo
    import writeback_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push_i,
    input  wb_entry_t push_data_i,
    input  logic      pop_i,
    output wb_entry_t head_o,
    output logic      full_o,
    output logic      empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wptr_q, wptr_d;
    logic [AW:0] rptr_q, rptr_d;
    wb_entry_t   mem_q [DEPTH];
    logic        do_push, do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign head_o  = mem_q[rptr_q[AW-1:0]];

    // Push is refused when full even if a pop happens on the same edge.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointer advance; low bits wrap modulo DEPTH naturally.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) wptr_d = wptr_q + {{AW{1'b0}}, 1'b1};
        if (do_pop)  rptr_d = rptr_q + {{AW{1'b0}}, 1'b1};
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage; contents are don't-care until written so no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= push_data_i;
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Merges execute-path and M-unit results into one registered RF write per cycle,
// and keeps the scoreboard of registers still owed by the M-unit.
module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                CLK,
    input  logic                RSTn,
    writeback_arbiter_if.slave  bus
);
    wb_entry_t push_ent, head;
    logic      full, empty;
    logic      pipe_wr, push, pop;

    logic      rf_we_q, rf_we_d;
    reg_addr_t rf_rd_q, rf_rd_d;
    xword_t    rf_wdata_q, rf_wdata_d;
    reg_mask_t pending_q, pending_d;
    reg_mask_t set_vec, clr_vec;

    // x0 targets are non-writes: a pipe rd=0 does not block a pop, md rd=0 is dropped.
    assign pipe_wr  = bus.pipe_valid && (bus.pipe_rd != '0);
    assign push     = bus.md_valid && !full && (bus.md_rd != '0);
    assign pop      = !pipe_wr && !empty;
    assign push_ent = '{rd: bus.md_rd, data: bus.md_data};

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (CLK),
        .rst_n      (RSTn),
        .push_i     (push),
        .push_data_i(push_ent),
        .pop_i      (pop),
        .head_o     (head),
        .full_o     (full),
        .empty_o    (empty)
    );

    // Priority mux: execute path first, then queue head; idle holds address/data.
    always_comb begin
        rf_we_d    = 1'b0;
        rf_rd_d    = rf_rd_q;
        rf_wdata_d = rf_wdata_q;
        if (pipe_wr) begin
            rf_we_d    = 1'b1;
            rf_rd_d    = bus.pipe_rd;
            rf_wdata_d = bus.pipe_data;
        end else if (pop) begin
            rf_we_d    = 1'b1;
            rf_rd_d    = head.rd;
            rf_wdata_d = head.data;
        end
    end

    // Scoreboard: issue sets, pop clears, set wins on collision, x0 never pending.
    always_comb begin
        set_vec   = bus.issue_valid ? reg_onehot(bus.issue_rd) : '0;
        clr_vec   = pop ? reg_onehot(head.rd) : '0;
        pending_d = (pending_q & ~clr_vec) | set_vec;
        pending_d[0] = 1'b0;
    end

    // Output and scoreboard registers.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            rf_we_q    <= 1'b0;
            rf_rd_q    <= '0;
            rf_wdata_q <= '0;
            pending_q  <= '0;
        end else begin
            rf_we_q    <= rf_we_d;
            rf_rd_q    <= rf_rd_d;
            rf_wdata_q <= rf_wdata_d;
            pending_q  <= pending_d;
        end
    end

    // Source operands or a second owner of an outstanding M-unit rd must stall.
    assign bus.hazard   = pending_q[bus.chk_rs1] | pending_q[bus.chk_rs2]
                        | (bus.issue_valid && pending_q[bus.issue_rd]);
    assign bus.pending  = pending_q;
    assign bus.md_ready = !full;
    assign bus.rf_we    = rf_we_q;
    assign bus.rf_rd    = rf_rd_q;
    assign bus.rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed vector bench for writeback_arbiter with a negedge-sampled RF model.
module tb_writeback_arbiter;
    import writeback_arbiter_pkg::*;

    logic CLK = 1'b0;
    logic RSTn;
    always #5 CLK = ~CLK;

    writeback_arbiter_if bus();

    writeback_arbiter #(.DEPTH(4)) dut (
        .CLK (CLK),
        .RSTn(RSTn),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    // Register file model: samples the write port on negedge.
    logic [31:0] rf_model [32];
    always @(negedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            for (int i = 0; i < 32; i++) rf_model[i] <= '0;
        end else if (bus.rf_we) begin
            rf_model[bus.rf_rd] <= bus.rf_wdata;
        end
    end

    // Execute-path writes must never target a register owed by the M-unit.
    always @(posedge CLK) begin
        if (RSTn && bus.pipe_valid && bus.pipe_rd != 0 && bus.pending[bus.pipe_rd]) begin
            $display("FAIL protocol: pipe write to pending x%0d", bus.pipe_rd);
            fails++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        pv;
        logic [4:0]  prd;
        logic [31:0] pd;
        logic        mv;
        logic [4:0]  mrd;
        logic [31:0] md;
        logic        iv;
        logic [4:0]  ird;
        logic [4:0]  rs1, rs2;
        logic        hz, rdy;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] wd;
        logic [31:0] pend;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(
        input logic pv, input logic [4:0] prd, input logic [31:0] pd,
        input logic mv, input logic [4:0] mrd, input logic [31:0] md,
        input logic iv, input logic [4:0] ird, input logic [4:0] rs1, input logic [4:0] rs2,
        input logic hz, input logic rdy,
        input logic we, input logic [4:0] rd, input logic [31:0] wd, input logic [31:0] pend);
        vec_t v;
        v.pv = pv; v.prd = prd; v.pd = pd;
        v.mv = mv; v.mrd = mrd; v.md = md;
        v.iv = iv; v.ird = ird; v.rs1 = rs1; v.rs2 = rs2;
        v.hz = hz; v.rdy = rdy;
        v.we = we; v.rd = rd; v.wd = wd; v.pend = pend;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic pv, input logic [4:0] prd, input logic [31:0] pd,
                         input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                         input logic iv, input logic [4:0] ird,
                         input logic [4:0] rs1, input logic [4:0] rs2);
        bus.pipe_valid = pv; bus.pipe_rd = prd; bus.pipe_data = pd;
        bus.md_valid = mv; bus.md_rd = mrd; bus.md_data = md;
        bus.issue_valid = iv; bus.issue_rd = ird;
        bus.chk_rs1 = rs1; bus.chk_rs2 = rs2;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    initial begin
        // T2/T3/T5/T6 vectors: inputs | pre-edge hazard, md_ready | post-edge rf_*, pending
        //         pv prd  pd            mv mrd md            iv ird rs1 rs2 hz rdy we rd  wd            pend
        vt.push_back(mk(1, 5, 32'hDEADBEEF, 0, 0, 0,           0, 0, 0, 0,   0, 1,  1, 5, 32'hDEADBEEF, 32'h0));
        vt.push_back(mk(0, 0, 0,            0, 0, 0,           0, 0, 0, 0,   0, 1,  0, 5, 32'hDEADBEEF, 32'h0));
        vt.push_back(mk(1, 3, 32'h33330001, 0, 0, 0,           1, 7, 0, 0,   0, 1,  1, 3, 32'h33330001, 32'h80));
        vt.push_back(mk(1, 3, 32'h33330002, 1, 7, 32'h12345678, 0, 0, 0, 0,  0, 1,  1, 3, 32'h33330002, 32'h80));
        vt.push_back(mk(0, 0, 0,            0, 0, 0,           0, 0, 7, 0,   1, 1,  1, 7, 32'h12345678, 32'h0));
        vt.push_back(mk(0, 0, 0,            0, 0, 0,           0, 0, 7, 0,   0, 1,  0, 7, 32'h12345678, 32'h0));
        vt.push_back(mk(0, 0, 0,            0, 0, 0,           1, 9, 0, 0,   0, 1,  0, 7, 32'h12345678, 32'h200));
        vt.push_back(mk(0, 0, 0,            0, 0, 0,           0, 0, 0, 9,   1, 1,  0, 7, 32'h12345678, 32'h200));
        vt.push_back(mk(0, 0, 0,            0, 0, 0,           1, 9, 0, 0,   1, 1,  0, 7, 32'h12345678, 32'h200));
        vt.push_back(mk(1, 4, 32'h44440000, 1, 9, 32'h99990000, 0, 0, 0, 0,  0, 1,  1, 4, 32'h44440000, 32'h200));
        vt.push_back(mk(0, 0, 0,            0, 0, 0,           1, 9, 0, 0,   1, 1,  1, 9, 32'h99990000, 32'h200));
        vt.push_back(mk(0, 0, 0,            0, 0, 0,           0, 0, 9, 0,   1, 1,  0, 9, 32'h99990000, 32'h200));
        vt.push_back(mk(0, 0, 0,            1, 9, 32'h99990001, 0, 0, 0, 0,  0, 1,  0, 9, 32'h99990000, 32'h200));
        vt.push_back(mk(0, 0, 0,            0, 0, 0,           0, 0, 0, 0,   0, 1,  1, 9, 32'h99990001, 32'h0));
        vt.push_back(mk(0, 0, 0,            1, 6, 32'h66660000, 1, 6, 0, 0,  0, 1,  0, 9, 32'h99990001, 32'h40));
        vt.push_back(mk(1, 0, 32'hBAD00000, 0, 0, 0,           0, 0, 0, 0,   0, 1,  1, 6, 32'h66660000, 32'h0));
        vt.push_back(mk(0, 0, 0,            1, 0, 32'hBAD00001, 0, 0, 0, 0,  0, 1,  0, 6, 32'h66660000, 32'h0));
        vt.push_back(mk(1, 0, 32'hBAD00002, 0, 0, 0,           0, 0, 0, 0,   0, 1,  0, 6, 32'h66660000, 32'h0));
        vt.push_back(mk(0, 0, 0,            0, 0, 0,           1, 0, 0, 0,   0, 1,  0, 6, 32'h66660000, 32'h0));

        // T1a: reset values
        RSTn = 1'b0;
        idle();
        #1;
        chk("reset rf_we", 32'(bus.rf_we), 0);
        chk("reset rf_rd", 32'(bus.rf_rd), 0);
        chk("reset rf_wdata", bus.rf_wdata, 0);
        chk("reset pending", bus.pending, 0);
        chk("reset md_ready", 32'(bus.md_ready), 1);
        #11;
        RSTn = 1'b1;
        tick();

        // Vector table
        foreach (vt[i]) begin
            drive(vt[i].pv, vt[i].prd, vt[i].pd, vt[i].mv, vt[i].mrd, vt[i].md,
                  vt[i].iv, vt[i].ird, vt[i].rs1, vt[i].rs2);
            #1;
            chk($sformatf("v%0d hazard", i), 32'(bus.hazard), 32'(vt[i].hz));
            chk($sformatf("v%0d md_ready", i), 32'(bus.md_ready), 32'(vt[i].rdy));
            tick();
            chk($sformatf("v%0d rf_we", i), 32'(bus.rf_we), 32'(vt[i].we));
            chk($sformatf("v%0d rf_rd", i), 32'(bus.rf_rd), 32'(vt[i].rd));
            chk($sformatf("v%0d rf_wdata", i), bus.rf_wdata, vt[i].wd);
            chk($sformatf("v%0d pending", i), bus.pending, vt[i].pend);
        end
        idle();
        @(negedge CLK);
        #1;
        chk("rf x5", rf_model[5], 32'hDEADBEEF);
        chk("rf x3", rf_model[3], 32'h33330002);
        chk("rf x7", rf_model[7], 32'h12345678);
        chk("rf x6", rf_model[6], 32'h66660000);
        chk("rf x0", rf_model[0], 32'h0);
        tick();

        // T4: fill the queue under continuous pipe writes
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 32'(i), 1, 5'(11 + i), 32'hA0 + 32'(i), 0, 0, 0, 0);
            #1;
            chk($sformatf("full push%0d md_ready", i), 32'(bus.md_ready), 1);
            tick();
            chk($sformatf("full push%0d rf_rd", i), 32'(bus.rf_rd), 1);
        end
        chk("full after 4 md_ready", 32'(bus.md_ready), 0);
        drive(1, 1, 32'h4, 1, 15, 32'hA4, 0, 0, 0, 0);
        tick();
        chk("full held md_ready", 32'(bus.md_ready), 0);
        chk("full held rf_wdata", bus.rf_wdata, 32'h4);
        // Pop with md_valid held while full: no push on this edge.
        drive(0, 0, 0, 1, 15, 32'hA4, 0, 0, 0, 0);
        #1;
        chk("full pop-edge md_ready", 32'(bus.md_ready), 0);
        tick();
        chk("drain0 rf_rd", 32'(bus.rf_rd), 11);
        chk("drain0 rf_wdata", bus.rf_wdata, 32'hA0);
        chk("drain0 md_ready", 32'(bus.md_ready), 1);
        tick();   // push 15 + pop 12
        chk("drain1 rf_rd", 32'(bus.rf_rd), 12);
        chk("drain1 rf_wdata", bus.rf_wdata, 32'hA1);
        chk("drain1 md_ready", 32'(bus.md_ready), 1);
        idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("drain%0d rf_we", i + 2), 32'(bus.rf_we), 1);
            chk($sformatf("drain%0d rf_rd", i + 2), 32'(bus.rf_rd), 32'(13 + i));
            chk($sformatf("drain%0d rf_wdata", i + 2), bus.rf_wdata, 32'hA2 + 32'(i));
        end
        tick();
        chk("drained rf_we", 32'(bus.rf_we), 0);

        // T1b: reset in the middle of traffic
        drive(1, 2, 32'h1, 1, 20, 32'hC0, 1, 20, 0, 0);
        tick();
        drive(1, 2, 32'h2, 1, 21, 32'hC1, 1, 21, 0, 0);
        tick();
        chk("pre-reset rf_we", 32'(bus.rf_we), 1);
        chk("pre-reset pending", bus.pending, 32'h0030_0000);
        drive(1, 2, 32'h3, 0, 0, 0, 0, 0, 0, 0);
        #1;
        RSTn = 1'b0;
        #1;
        chk("async reset rf_we", 32'(bus.rf_we), 0);
        chk("async reset pending", bus.pending, 0);
        chk("async reset md_ready", 32'(bus.md_ready), 1);
        idle();
        #3;
        RSTn = 1'b1;
        tick();
        chk("post-reset rf_we0", 32'(bus.rf_we), 0);
        tick();
        chk("post-reset rf_we1", 32'(bus.rf_we), 0);
        chk("post-reset pending", bus.pending, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
